// File: rtl/agu_arbiter.sv
// Two-requester arbiter in front of a shared LC-3b address-generation unit with a one-entry result slot.
// Define AGU_FIXED_PRIO_EN to make requester 1 always win simultaneous requests (no rotating pointer).
module agu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OFF_W = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [2:0]       mode0,
  input  logic [WIDTH-1:0] base0,
  input  logic [OFF_W-1:0] off0,
  output logic             ack0,
  input  logic             req1,
  input  logic [2:0]       mode1,
  input  logic [WIDTH-1:0] base1,
  input  logic [OFF_W-1:0] off1,
  output logic             ack1,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_addr,
  input  logic             resp_ready,
  output logic             dbg_state_o
);

  // Handshakes: a requester holds req and its fields stable until its one-cycle
  // ack; the slot transfers a result when resp_valid & resp_ready at a rising edge.

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_addr_q, resp_addr_d;
  logic             drain, accept, grant1;
  logic [WIDTH-1:0] calc0, calc1;

  function automatic logic [WIDTH-1:0] agu_calc(input logic [2:0]       mode,
                                                input logic [WIDTH-1:0] base,
                                                input logic [OFF_W-1:0] off);
    logic [WIDTH-1:0] ext;
    logic [WIDTH-1:0] sum;
    ext = '0;
    case (mode)
      3'd0: ext = {{(WIDTH-7){off[5]}}, off[5:0], 1'b0};
      3'd1: ext = {{(WIDTH-10){off[8]}}, off[8:0], 1'b0};
      3'd2: ext = {{(WIDTH-12){off[10]}}, off[10:0], 1'b0};
      3'd3: ext = {{(WIDTH-6){off[5]}}, off[5:0]};
      default: ext = '0;
    endcase
    sum = base + ext;
    // TRAP vectors are absolute: the base operand does not participate.
    if (mode == 3'd4) sum = {{(WIDTH-9){1'b0}}, off[7:0], 1'b0};
    return sum;
  endfunction

  assign calc0 = agu_calc(mode0, base0, off0);
  assign calc1 = agu_calc(mode1, base1, off1);

`ifdef AGU_FIXED_PRIO_EN
  assign grant1 = req1;
`else
  logic ptr_q, ptr_d;

  assign grant1 = (req0 && req1) ? ptr_q : req1;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = ~grant1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end
`endif

  assign drain  = (state_q == FULL) && resp_ready;
  // Gating with reset_n keeps ack low while reset is held.
  assign accept = reset_n && (req0 || req1) && ((state_q == EMPTY) || drain);

  always_comb begin
    state_d     = state_q;
    resp_id_d   = resp_id_q;
    resp_addr_d = resp_addr_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (drain && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      resp_id_d   = grant1;
      resp_addr_d = grant1 ? calc1 : calc0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      resp_id_q   <= 1'b0;
      resp_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      resp_id_q   <= resp_id_d;
      resp_addr_q <= resp_addr_d;
    end
  end

  assign ack0        = accept && !grant1;
  assign ack1        = accept && grant1;
  assign resp_valid  = (state_q == FULL);
  assign resp_id     = resp_id_q;
  assign resp_addr   = resp_addr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_agu_arbiter.sv
// Bench for agu_arbiter: directed requests plus a cycle model with a scoreboard of expected results.
// Honors AGU_FIXED_PRIO_EN the same way as the design.
module tb_agu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1, ack0, ack1;
  logic [2:0]  mode0, mode1;
  logic [15:0] base0, base1;
  logic [10:0] off0, off1;
  logic        resp_valid, resp_id, resp_ready, dbg_state_o;
  logic [15:0] resp_addr;

  int total = 0;
  int bad   = 0;

  logic [16:0] exp_q[$];
  bit          m_full = 0;
  bit          m_ptr  = 0;

  agu_arbiter #(.WIDTH(16), .OFF_W(11)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .mode0(mode0), .base0(base0), .off0(off0), .ack0(ack0),
    .req1(req1), .mode1(mode1), .base1(base1), .off1(off1), .ack1(ack1),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_addr(resp_addr),
    .resp_ready(resp_ready), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_addr(input logic [2:0] m, input logic [15:0] b,
                                             input logic [10:0] o);
    int v;
    int sum;
    v = 0;
    case (m)
      3'd0: begin v = int'(o[5:0]); if (v >= 32)   v -= 64;   v = v * 2; end
      3'd1: begin v = int'(o[8:0]); if (v >= 256)  v -= 512;  v = v * 2; end
      3'd2: begin v = int'(o);      if (v >= 1024) v -= 2048; v = v * 2; end
      3'd3: begin v = int'(o[5:0]); if (v >= 32)   v -= 64;   end
      default: v = 0;
    endcase
    sum = int'(b) + v;
    if (m == 3'd4) sum = int'(o[7:0]) * 2;
    return sum[15:0];
  endfunction

  // scoreboard / cycle model: evaluates the cycle ending at the next rising edge
  always @(negedge clk) begin
    bit drain, acc, g1;
    logic [16:0] e;
    if (!reset_n) begin
      m_full = 0;
      m_ptr  = 0;
      exp_q.delete();
      chk("rst_valid", resp_valid, 1'b0);
      chk("rst_addr", resp_addr, 16'h0);
      chk("rst_ack", {ack0, ack1}, 2'b00);
    end else begin
      drain = m_full && resp_ready;
      acc   = (req0 || req1) && (!m_full || drain);
`ifdef AGU_FIXED_PRIO_EN
      g1 = req1;
`else
      g1 = (req0 && req1) ? m_ptr : req1;
`endif
      chk("valid", resp_valid, m_full);
      chk("dbg_state", dbg_state_o, m_full);
      chk("ack0", ack0, acc && !g1);
      chk("ack1", ack1, acc && g1);
      if (m_full) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = drain ? exp_q.pop_front() : exp_q[0];
          chk("resp_id", resp_id, e[16]);
          chk("resp_addr", resp_addr, e[15:0]);
        end
      end
      if (acc) begin
        exp_q.push_back(g1 ? {1'b1, model_addr(mode1, base1, off1)}
                           : {1'b0, model_addr(mode0, base0, off0)});
        m_ptr = !g1;
      end
      m_full = acc || (m_full && !drain);
    end
  end

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit id, input logic [2:0] m, input logic [15:0] b,
                      input logic [10:0] o, input logic [15:0] exp_a);
    bit got;
    got = 0;
    if (id) begin req1 = 1; mode1 = m; base1 = b; off1 = o; end
    else    begin req0 = 1; mode0 = m; base0 = b; off0 = o; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (id ? ack1 : ack0) got = 1;
      step();
    end
    chk("ack_seen", got, 1);
    req0 = 0;
    req1 = 0;
    @(negedge clk);
    chk("direct_valid", resp_valid, 1);
    chk("direct_id", resp_id, id);
    chk("direct_addr", resp_addr, exp_a);
    step();
  endtask

  initial begin
    bit g;
    logic [3:0] pat;
    reset_n = 0; req0 = 0; req1 = 0; resp_ready = 1;
    mode0 = 0; mode1 = 0; base0 = 0; base1 = 0; off0 = 0; off1 = 0;
    #2;
    chk("reset_valid", resp_valid, 0);
    chk("reset_id", resp_id, 0);
    chk("reset_addr", resp_addr, 0);
    step(); step();
    reset_n = 1;

    send(0, 3'd2, 16'h3000, 11'h7FF, 16'h2FFE);
    send(1, 3'd4, 16'hFFFF, 11'h025, 16'h004A);
    send(1, 3'd0, 16'hFFFE, 11'h001, 16'h0000);
    send(1, 3'd3, 16'h1000, 11'h020, 16'h0FE0);
    send(1, 3'd6, 16'h1234, 11'h3AB, 16'h1234);
    send(0, 3'd1, 16'h0100, 11'h1FF, 16'h00FE);

    // both requesting continuously; last grant was to 0 so pointer is at 1 in RR,
    // one req1-only grant first to bring the pointer back to 0
    send(1, 3'd5, 16'h0042, 11'h000, 16'h0042);
`ifdef AGU_FIXED_PRIO_EN
    pat = 4'b1111;
`else
    pat = 4'b1010;
`endif
    req0 = 1; mode0 = 3'd0; base0 = 16'h2000; off0 = 11'h03F;
    req1 = 1; mode1 = 3'd3; base1 = 16'h4000; off1 = 11'h005;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g = ack1;
      chk("rr_grant", g, pat[i]);
      chk("rr_one_ack", ack0 ^ ack1, 1);
      step();
    end
    req0 = 0; req1 = 0;
    step(); step();

    // stall with req0 pending
    resp_ready = 0;
    req0 = 1; mode0 = 3'd2; base0 = 16'h0100; off0 = 11'h001;
    @(negedge clk);
    chk("stall_first_ack", ack0, 1);
    step();
    off0 = 11'h002;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_no_ack", ack0, 0);
      chk("stall_hold_addr", resp_addr, 16'h0102);
      step();
    end
    resp_ready = 1;
    @(negedge clk);
    chk("drain_accept_ack", ack0, 1);
    chk("drain_old_addr", resp_addr, 16'h0102);
    step();
    req0 = 0;
    @(negedge clk);
    chk("new_addr", resp_addr, 16'h0104);
    step();

    // reset while full with requests pending
    resp_ready = 0;
    req0 = 1; mode0 = 3'd5; base0 = 16'h0777;
    @(negedge clk);
    step();
    req1 = 1; mode1 = 3'd5; base1 = 16'h0888;
    #1;
    chk("pre_rst_valid", resp_valid, 1);
    reset_n = 0;
    #1;
    chk("async_valid_drop", resp_valid, 0);
    chk("async_addr_clear", resp_addr, 0);
    chk("no_ack_in_reset", {ack0, ack1}, 2'b00);
    step();
    reset_n = 1;
    resp_ready = 1;
    @(negedge clk);
`ifdef AGU_FIXED_PRIO_EN
    chk("post_rst_grant", {ack0, ack1}, 2'b01);
`else
    chk("post_rst_grant", {ack0, ack1}, 2'b10);
`endif
    step();
    req0 = 0; req1 = 0;
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    chk("end_valid", resp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/agu_arbiter.md
Name: agu_arbiter

Overview:
- Shares a single address-generation unit (base + extended offset) between two requesters: requester 0 is the fetch/branch-target path, requester 1 is the memory-stage path.
- Internally performs the LC-3b offset extensions: ADJ (sign-extend of offset<<1), SEXT, and ZEXT<<1.
- Runs a round-robin arbiter, a one-entry output slot with valid/ready handshake, and a two-state slot FSM.
- Sits between the pipeline's address consumers and the shared AGU adder.

Parameters:
- WIDTH, 16, datapath/address width (lc3b_word).
- OFF_W, 11, width of the raw offset field carried by each request (largest LC-3b offset, PCoffset11).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 request; held with its fields stable until ack0.
- mode0  input  3  requester 0 extension mode.
- base0  input  WIDTH  requester 0 base value.
- off0  input  OFF_W  requester 0 raw offset.
- ack0  output  1  one-cycle acceptance pulse for requester 0.
- req1, mode1, base1, off1, ack1: same as above, for requester 1.
- resp_valid  output  1  result slot full.
- resp_id  output  1  requester that owns the result.
- resp_addr  output  WIDTH  computed address.
- resp_ready  input  1  consumer takes result when resp_valid & resp_ready.

Behaviour:
- Reset (asynchronous on reset_n low):
  - resp_valid=0, resp_id=0, resp_addr=0, ack0=ack1=0.
  - Priority pointer = 0; FSM = EMPTY.
  - Assertion mid-operation discards any held result immediately. No ack is generated until reset_n is sampled high.
- Modes: ext is WIDTH bits; result = base + ext, truncated mod 2^WIDTH.
  - 0 ADJ6: $signed({off[5:0],0}).
  - 1 ADJ9: $signed({off[8:0],0}).
  - 2 ADJ11: $signed({off[10:0],0}).
  - 3 SEXT6: $signed(off[5:0]).
  - 4 TRAP: result = zext({off[7:0],0}); base is ignored.
  - 5-7: reserved; ext = 0, so result = base.
- FSM:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain (resp_valid & resp_ready) with no accept.
  - FULL -> FULL on drain plus a same-cycle accept, or on stall.
- Accept condition: at least one req is high AND (state==EMPTY OR drain this cycle).
  - The ack is combinational in the accept cycle and lasts one cycle.
  - The result is registered, so resp_valid rises the next cycle. Latency is 1 cycle, with back-to-back throughput of 1 result per cycle when resp_ready is held high.
- Arbitration:
  - Only one requester is granted.
  - If both request, the pointer's requester wins. After any grant, the pointer moves to the non-granted requester.
  - A single requester wins regardless of the pointer, and the pointer still updates.
- Stall: while FULL and resp_ready=0, no ack; resp_id and resp_addr are held stable.
- A requester dropping req without ack is legal; that request is simply not served.
- resp_ready while EMPTY is ignored.

Optional Feature:
- Macro: AGU_FIXED_PRIO_EN.
- Defined: requester 1 always wins a simultaneous request; the priority pointer is removed and requester 0 can starve.
- Undefined: round-robin as in Behaviour.

Test Plan:
- Reset, then req0 mode=2 base=0x3000 off=0x7FF, resp_ready=1:
  - ack0 in cycle 1; next cycle resp_valid=1, resp_id=0, resp_addr=0x2FFE.
- req1 mode=4 off=0x25, base=0xFFFF:
  - resp_addr=0x004A, base ignored.
- req1 mode=0 base=0xFFFE off=0x01 (wrap):
  - resp_addr=0x0000.
- req1 mode=3 base=0x1000 off=0x20:
  - resp_addr=0x0FE0.
- req1 mode=6 base=0x1234:
  - resp_addr=0x1234 (reserved mode, ext=0).
- Both req held high for 4 accepts, resp_ready=1:
  - Default build: grants 0,1,0,1, one per cycle.
  - With AGU_FIXED_PRIO_EN: grants 1,1,1,1.
- resp_ready=0 for 3 cycles with req0 pending:
  - No ack; resp_addr is held.
  - When resp_ready rises, drain and accept happen in the same cycle; the new result appears the next cycle.
- reset_n pulsed low while resp_valid=1 and req0 pending:
  - resp_valid drops immediately and the pointer returns to 0.
  - After release, req0 is acked on the first clock.
